// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction prefetch unit (FSM states, queue entry)
// and a small state-decode helper.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 16;
  localparam int unsigned FETCH_INSTR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A memory request is on the bus in both REQ and DISCARD.
  function automatic logic req_in_flight(input fetch_state_e st);
    return (st == ST_REQ) || (st == ST_DISCARD);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of {pc, instr} pairs with occupancy count
// and a synchronous flush that overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_pc,
  input  logic [INSTR_W-1:0]       push_instr,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_pc,
  output logic [INSTR_W-1:0]       head_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_mem_r    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Qualify push/pop so the buffer can never over- or underflow.
  always_comb begin
    do_push_s = push && !flush && (!full || pop);
    do_pop_s  = pop && !flush && !empty;
  end

  // Entry storage; a flushed push is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_r[i]    <= '0;
        instr_mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      pc_mem_r[wr_ptr_r]    <= push_pc;
      instr_mem_r[wr_ptr_r] <= push_instr;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_pc    = pc_mem_r[rd_ptr_r];
  assign head_instr = instr_mem_r[rd_ptr_r];
  assign count      = count_r;
  assign full       = (count_r == CNT_W'(DEPTH));
  assign empty      = (count_r == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch unit -- walks fetch_pc, issues one outstanding read at a time and
// queues returned words. Define FETCH_BYPASS_EN for same-cycle delivery into an empty queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned    CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  fetch_state_e       state_r;
  fetch_state_e       state_nxt_s;
  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [ADDR_W-1:0]  fetch_pc_nxt_s;
  logic               mem_req_r;
  logic               mem_req_nxt_s;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [ADDR_W-1:0]  mem_addr_nxt_s;

  logic               req_ack_s;
  logic               bypass_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W:0]     count_nxt_s;
  logic               room_s;

  logic [ADDR_W-1:0]  head_pc_s;
  logic [INSTR_W-1:0] head_instr_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  fetch_fifo #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (push_s),
    .push_pc    (mem_addr_r),
    .push_instr (mem_rdata),
    .pop        (pop_s),
    .head_pc    (head_pc_s),
    .head_instr (head_instr_s),
    .count      (fifo_count_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  // Queue traffic this cycle and whether another request still fits afterwards.
  always_comb begin
    req_ack_s = (state_r == ST_REQ) && mem_ack;
`ifdef FETCH_BYPASS_EN
    bypass_s  = req_ack_s && fifo_empty_s && !redirect;
`else
    bypass_s  = 1'b0;
`endif
    // A bypassed word taken by decode never enters the queue.
    push_s      = req_ack_s && !redirect && !(bypass_s && instr_ready);
    pop_s       = instr_ready && !fifo_empty_s && !redirect;
    count_nxt_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, push_s} - {{CNT_W{1'b0}}, pop_s};
    room_s      = (count_nxt_s < DEPTH_EXT);
  end

  // FSM state, fetch PC and the registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      mem_req_r  <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      mem_req_r  <= mem_req_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
    end
  end

  // Next-state: redirect always wins; a request on the bus must still be retired.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // A redirect empties the queue, so room is guaranteed.
        if (fetch_en && (redirect || !fifo_full_s)) state_nxt_s = ST_REQ;
        else                                        state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (!redirect && fetch_en && room_s) state_nxt_s = ST_REQ;
          else                                 state_nxt_s = ST_IDLE;
        end else if (redirect) begin
          state_nxt_s = ST_DISCARD;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (mem_ack) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_DISCARD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of fetch_pc and the memory request registers.
  always_comb begin
    mem_req_nxt_s = req_in_flight(state_nxt_s);

    if (redirect)       fetch_pc_nxt_s = redirect_pc;
    else if (req_ack_s) fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(1);
    else                fetch_pc_nxt_s = fetch_pc_r;

    if ((state_r == ST_IDLE) && (state_nxt_s == ST_REQ)) begin
      mem_addr_nxt_s = redirect ? redirect_pc : fetch_pc_r;
    end else if (req_ack_s && (state_nxt_s == ST_REQ)) begin
      mem_addr_nxt_s = fetch_pc_r + ADDR_W'(1);
    end else begin
      mem_addr_nxt_s = mem_addr_r;
    end
  end

  // Decode-side view: queue head, or the returning word when bypassing.
  always_comb begin
    if (bypass_s) begin
      instr_valid = 1'b1;
      instr       = mem_rdata;
      instr_pc    = mem_addr_r;
    end else begin
      instr_valid = !fifo_empty_s;
      instr       = head_instr_s;
      instr_pc    = head_pc_s;
    end
  end

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a program-order
// reference: delivered words must follow the PC stream from reset/redirect with no gaps.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int total;
  int passed;

  logic [15:0] got_pc[$];
  logic [15:0] got_instr[$];
  logic [15:0] ack_addr[$];

  fetch_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // One clock: memory answers only a live request; decode takes the head if valid and not voided.
  task automatic step(input logic ack, input logic rdy, input logic redir, input logic [15:0] rpc);
    mem_ack     = ack && mem_req;
    mem_rdata   = word_at(mem_addr);
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    if (instr_valid && instr_ready && !redirect) begin
      got_pc.push_back(instr_pc);
      got_instr.push_back(instr);
    end
    if (mem_ack) ack_addr.push_back(mem_addr);
    @(posedge clk);
    #1;
    mem_ack  = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic apply_reset(input logic en);
    rst_n = 1'b0; fetch_en = en; mem_ack = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000; mem_rdata = 16'h0000;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    got_pc.delete(); got_instr.delete(); ack_addr.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000; mem_rdata = 16'h0000;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %0b want 0", mem_req); else passed++;
    total++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (instr !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", instr); else passed++;
    total++; if (instr_pc !== 16'h0000) $display("FAIL reset_instr_pc: got %h want 0000", instr_pc); else passed++;
    rst_n = 1'b1;
    got_pc.delete(); got_instr.delete(); ack_addr.delete();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    total++; if (mem_req !== 1'b1) $display("FAIL first_req: got %0b want 1", mem_req); else passed++;
    total++; if (mem_addr !== 16'h0000) $display("FAIL first_addr: got %h want 0000", mem_addr); else passed++;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
    total++; if (instr_valid !== 1'b1) $display("FAIL pre_reset_valid: got %0b want 1", instr_valid); else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) $display("FAIL async_reset_req: got %0b want 0", mem_req); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL async_reset_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (mem_addr !== 16'h0000) $display("FAIL async_reset_addr: got %h want 0000", mem_addr); else passed++;
  endtask

  task automatic test_stream();
    int exp_n;
    int low_req;
    apply_reset(1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    low_req = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      if (mem_req !== 1'b1) low_req++;
    end
`ifdef FETCH_BYPASS_EN
    exp_n = 20;
`else
    exp_n = 19;
`endif
    total++; if (low_req != 0) $display("FAIL stream_req_gap: got %0d idle cycles want 0", low_req); else passed++;
    total++; if (ack_addr.size() != 20) $display("FAIL stream_acks: got %0d want 20", ack_addr.size()); else passed++;
    total++; if (got_pc.size() != exp_n) $display("FAIL stream_count: got %0d want %0d", got_pc.size(), exp_n); else passed++;
    for (int i = 0; i < got_pc.size(); i++) begin
      total++;
      if (got_pc[i] !== 16'(i) || got_instr[i] !== word_at(16'(i)))
        $display("FAIL stream_word[%0d]: got pc %h instr %h want pc %h instr %h", i, got_pc[i], got_instr[i], 16'(i), word_at(16'(i)));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    apply_reset(1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
    total++; if (ack_addr.size() != 4) $display("FAIL bp_acks: got %0d want 4", ack_addr.size()); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL bp_req_drop: got %0b want 0", mem_req); else passed++;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'hA5A5)
      $display("FAIL bp_head_hold: got v%0b pc %h instr %h want v1 pc 0000 instr a5a5", instr_valid, instr_pc, instr);
    else passed++;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    total++; if (got_pc.size() < 15) $display("FAIL bp_resume_count: got %0d want >=15", got_pc.size()); else passed++;
    bad = 0;
    for (int i = 0; i < ack_addr.size(); i++) if (ack_addr[i] !== 16'(i)) bad++;
    total++; if (bad != 0) $display("FAIL bp_ack_order: got %0d out-of-order addrs want 0", bad); else passed++;
    bad = 0;
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] !== 16'(i) || got_instr[i] !== word_at(16'(i))) bad++;
    total++; if (bad != 0) $display("FAIL bp_delivery: got %0d bad words want 0", bad); else passed++;
  endtask

  task automatic test_redirect_wait();
    logic [15:0] old_addr;
    int n_before;
    int bad;
    apply_reset(1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    old_addr = mem_addr;
    n_before = got_pc.size();
    step(1'b0, 1'b1, 1'b1, 16'h0100);
    total++; if (instr_valid !== 1'b0) $display("FAIL rw_flush_valid: got %0b want 0", instr_valid); else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (mem_req !== 1'b1 || mem_addr !== old_addr)
        $display("FAIL rw_discard_hold: got req %0b addr %h want req 1 addr %h", mem_req, mem_addr, old_addr);
      else passed++;
      step(1'b0, 1'b1, 1'b0, 16'h0000);
    end
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    total++; if (instr_valid !== 1'b0) $display("FAIL rw_drop: got valid %0b want 0", instr_valid); else passed++;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    total++;
    if (ack_addr.size() < 7 || ack_addr[5] !== old_addr || ack_addr[6] !== 16'h0100)
      $display("FAIL rw_next_req: got %0d acks want ack[5]=%h ack[6]=0100", ack_addr.size(), old_addr);
    else passed++;
    total++; if (got_pc.size() < n_before + 5) $display("FAIL rw_count: got %0d want >=%0d", got_pc.size(), n_before + 5); else passed++;
    bad = 0;
    for (int i = 0; i < got_pc.size(); i++) begin
      if (i < n_before) begin
        if (got_pc[i] !== 16'(i) || got_instr[i] !== word_at(16'(i))) bad++;
      end else begin
        if (got_pc[i] !== 16'(256 + i - n_before) || got_instr[i] !== word_at(16'(256 + i - n_before))) bad++;
      end
    end
    total++; if (bad != 0) $display("FAIL rw_stream: got %0d bad words want 0", bad); else passed++;
  endtask

  task automatic test_redirect_ack();
    int bad;
    apply_reset(1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
    total++; if (instr_valid !== 1'b1) $display("FAIL ra_nonempty: got %0b want 1", instr_valid); else passed++;
    step(1'b1, 1'b0, 1'b1, 16'h0200);
    total++; if (instr_valid !== 1'b0) $display("FAIL ra_flush_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL ra_idle: got req %0b want 0", mem_req); else passed++;
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0200)
      $display("FAIL ra_restart: got req %0b addr %h want req 1 addr 0200", mem_req, mem_addr);
    else passed++;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    total++; if (got_pc.size() < 5) $display("FAIL ra_count: got %0d want >=5", got_pc.size()); else passed++;
    bad = 0;
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] !== 16'(512 + i) || got_instr[i] !== word_at(16'(512 + i))) bad++;
    total++; if (bad != 0) $display("FAIL ra_stream: got %0d bad words want 0", bad); else passed++;
  endtask

  task automatic test_wrap();
    int bad;
    apply_reset(1'b1);
    step(1'b0, 1'b1, 1'b1, 16'hFFFE);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 16'hFFFE)
      $display("FAIL wrap_idle_redirect: got req %0b addr %h want req 1 addr fffe", mem_req, mem_addr);
    else passed++;
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    total++; if (mem_addr !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want ffff", mem_addr); else passed++;
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    total++; if (mem_addr !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", mem_addr); else passed++;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
    total++; if (got_pc.size() < 4) $display("FAIL wrap_count: got %0d want >=4", got_pc.size()); else passed++;
    bad = 0;
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] !== 16'(65534 + i) || got_instr[i] !== word_at(16'(65534 + i))) bad++;
    total++; if (bad != 0) $display("FAIL wrap_stream: got %0d bad words want 0", bad); else passed++;
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    apply_reset(1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    mem_ack = 1'b1; mem_rdata = word_at(mem_addr); instr_ready = 1'b1;
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'hA5A5)
      $display("FAIL bypass_same_cycle: got v%0b pc %h instr %h want v1 pc 0000 instr a5a5", instr_valid, instr_pc, instr);
    else passed++;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL bypass_not_written: got valid %0b want 0", instr_valid); else passed++;
  endtask
`endif

  task automatic test_random();
    logic [15:0] model_pc;
    logic        prev_req;
    logic [15:0] prev_addr;
    logic        ack;
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    int          n0;
    int          delivered;
    apply_reset(1'b1);
    model_pc  = 16'h0000;
    delivered = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      fetch_en  = ($urandom_range(0, 9) != 0);
      ack       = ($urandom_range(0, 9) < 6);
      rdy       = ($urandom_range(0, 9) < 7);
      redir     = ($urandom_range(0, 39) == 0);
      rpc       = 16'($urandom);
      prev_req  = mem_req;
      prev_addr = mem_addr;
      n0        = got_pc.size();
      step(ack, rdy, redir, rpc);
      if (prev_req && !ack) begin
        total++;
        if (mem_req !== 1'b1 || mem_addr !== prev_addr)
          $display("FAIL rnd_req_hold[%0d]: got req %0b addr %h want req 1 addr %h", cyc, mem_req, mem_addr, prev_addr);
        else passed++;
      end
      if (got_pc.size() > n0) begin
        total++;
        if (got_pc[n0] !== model_pc || got_instr[n0] !== word_at(model_pc))
          $display("FAIL rnd_word[%0d]: got pc %h instr %h want pc %h instr %h", cyc, got_pc[n0], got_instr[n0], model_pc, word_at(model_pc));
        else passed++;
        model_pc = model_pc + 16'd1;
        delivered++;
      end
      if (redir) begin
        total++;
        if (instr_valid !== 1'b0) $display("FAIL rnd_flush[%0d]: got valid %0b want 0", cyc, instr_valid); else passed++;
        model_pc = rpc;
      end
    end
    total++; if (delivered < 50) $display("FAIL rnd_progress: got %0d words want >=50", delivered); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch unit sitting between the program counter logic and instruction memory in mini_cpu. It walks a fetch PC, issues one-outstanding memory reads over a req/ack handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue. The decode stage drains the queue over a valid/ready handshake. A redirect flushes the queue and restarts fetch at a new PC.

## Interface
- ADDR_W, 16, address / PC width
- INSTR_W, 16, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch PC after reset
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- FETCH_EN  in  1  permits new memory requests; an outstanding request always completes
- REDIRECT  in  1  flush queue and restart at REDIRECT_PC
- REDIRECT_PC  in  ADDR_W  new fetch PC
- MEM_REQ  out  1  read request, registered
- MEM_ADDR  out  ADDR_W  read address, registered, stable while MEM_REQ=1
- MEM_ACK  in  1  memory accepts request; MEM_RDATA valid this cycle
- MEM_RDATA  in  INSTR_W  read data
- INSTR_VALID  out  1  queue head valid
- INSTR  out  INSTR_W  head instruction
- INSTR_PC  out  ADDR_W  address of head instruction
- INSTR_READY  in  1  decode accepts head

## Operation
- Clock CLK; reset RST_N, asynchronous, active-low.
- States: IDLE, REQ, DISCARD.
- IDLE: if FETCH_EN and count < DEPTH, go to REQ with MEM_ADDR=fetch_pc.
- REQ: MEM_REQ=1. On MEM_ACK: push {MEM_ADDR, MEM_RDATA}; fetch_pc+1. Stay in REQ with the next address if FETCH_EN and there is still space after this push and any pop in the same cycle. Otherwise go to IDLE.
- Space rule: a request is issued only if count + 1 ≤ DEPTH, with the outstanding request counted. The queue therefore never overflows.
- REDIRECT (highest priority):
  - Queue is emptied and fetch_pc is set to REDIRECT_PC.
  - Any pop in the same cycle is void.
  - If in REQ without MEM_ACK in that cycle, go to DISCARD. DISCARD keeps MEM_REQ/MEM_ADDR unchanged until MEM_ACK and drops the data, then goes to IDLE.
  - If REDIRECT and MEM_ACK coincide, the acked data is dropped and the state goes to IDLE.
- REDIRECT during DISCARD: update fetch_pc only; remain in DISCARD.
- Push and pop in the same cycle: count unchanged; this is legal when full.
- Pop with the queue empty cannot occur, because INSTR_VALID=0.
- fetch_pc+1 wraps modulo 2^ADDR_W. The queue pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- INSTR/INSTR_PC hold their value while INSTR_VALID=1 and INSTR_READY=0.

## Timing
- Reset values: MEM_REQ=0, MEM_ADDR=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0, state IDLE, fetch_pc=RESET_PC, count=0.
- First rising edge with RST_N=1 and FETCH_EN=1: MEM_REQ=1, MEM_ADDR=RESET_PC.
- Ack in cycle N: entry is written at the end of N; INSTR_VALID=1 in N+1 (without bypass).
- Back-to-back: with MEM_ACK held high, the unit sustains one instruction per cycle.
- REDIRECT in cycle N:
  - INSTR_VALID=0 in N+1.
  - If the state was not REQ/DISCARD, MEM_REQ=1 with MEM_ADDR=REDIRECT_PC in N+1 (FETCH_EN=1).
- Reset asserted mid-operation clears everything immediately. Outstanding memory transactions are abandoned.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the queue is empty, the state is REQ, MEM_ACK=1 and REDIRECT=0, MEM_RDATA/MEM_ADDR are driven combinationally to INSTR/INSTR_PC with INSTR_VALID=1 in the same cycle.
  - If INSTR_READY=1 that cycle, the entry is not written.
- FETCH_BYPASS_EN undefined: the path from MEM_ACK to the outputs is fully registered through the queue, and ack-to-valid latency is one cycle.

## Structure
- Package fetch_pkg: state enum (IDLE, REQ, DISCARD) and the queue-entry struct {pc, instr} parametrised by width constants.
- Sub-module fetch_fifo:
  - Holds storage, read/write pointers, count, full/empty and a synchronous flush.
  - fetch_queue holds the FSM, fetch_pc, the space check and the bypass mux.

## Test plan
- Reset, FETCH_EN=1, memory acks every cycle, RDATA=addr^16'hA5A5: first MEM_ADDR=0. INSTR sequence 0xA5A5, 0xA5A4… with PCs 0,1,2. One instruction per cycle.
- INSTR_READY=0, DEPTH=4: exactly 4 acks are accepted. MEM_REQ drops and stays 0. Raising READY resumes fetch at PC 4 with no loss or duplication.
- REDIRECT to 0x0100 while MEM_REQ waits for ack (ack delayed 3 cycles): the unit enters DISCARD and the acked data is dropped. The next request is at 0x0100, and the first INSTR_PC is 0x0100.
- REDIRECT and MEM_ACK in the same cycle with a non-empty queue: the queue is emptied and the acked data is dropped. INSTR_VALID=0 next cycle.
- fetch_pc=0xFFFF: the next MEM_ADDR is 0x0000.
- Bypass, only with FETCH_BYPASS_EN: empty queue, ack with READY=1 gives INSTR_VALID=1 in the ack cycle and count stays 0.
